// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop rx synchronizer, 4x-oversampling tick divider,
// start-bit qualification at half a bit, mid-bit data sampling and stop-bit check.
module uart_rx #(
  parameter int CLK_FREQ  = 5_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 4);
  localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  generate
    if (TICK_DIV < 2) begin : g_bad_tick_div
      $error("uart_rx: CLK_FREQ / (BAUD_RATE*4) must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [1:0]      rx_sync_r;
  logic            rx_s;
  logic [CW-1:0]   cnt_r;
  logic [1:0]      sub_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shreg_r;
  logic [7:0]      rx_data_r;
  logic            data_valid_r;
  logic            frame_error_r;
  logic            busy_r;
  logic            tick_s;

  assign rx_s   = rx_sync_r[1];
  assign tick_s = (cnt_r == CW'(TICK_DIV - 1));

  // Two-flop synchronizer on the asynchronous line, resetting to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end

  // Receive FSM with its tick divider, sub-tick phase and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      sub_r         <= 2'd0;
      bit_idx_r     <= 3'd0;
      shreg_r       <= 8'h00;
      rx_data_r     <= 8'h00;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
    end else if (!enable) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      sub_r         <= 2'd0;
      bit_idx_r     <= 3'd0;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      if (state_r == IDLE) begin
        cnt_r <= '0;
      end else if (tick_s) begin
        cnt_r <= '0;
        sub_r <= sub_r + 2'd1;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end

      // Phase overrides below are placed after the generic sub-tick advance so they win.
      case (state_r)
        IDLE: begin
          sub_r     <= 2'd0;
          bit_idx_r <= 3'd0;
          if (!rx_s) begin
            state_r <= START;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (tick_s && sub_r == 2'd1) begin
            if (rx_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= DATA;
              sub_r     <= 2'd0;
              bit_idx_r <= 3'd0;
            end
          end
        end
        DATA: begin
          if (tick_s && sub_r == 2'd3) begin
            shreg_r[bit_idx_r] <= rx_s;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              sub_r   <= 2'd0;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (tick_s && sub_r == 2'd3) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            if (rx_s) begin
              rx_data_r    <= shreg_r;
              data_valid_r <= 1'b1;
            end else begin
              frame_error_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          sub_r   <= 2'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data     = rx_data_r;
  assign data_valid  = data_valid_r;
  assign frame_error = frame_error_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames against a line-level
// sampling model (level of the driven waveform at each expected mid-bit instant).
module tb_uart_rx;

  localparam int CLK_FREQ  = 400;
  localparam int BAUD_RATE = 10;
  localparam int TD        = CLK_FREQ / (BAUD_RATE * 4);
  localparam int BIT       = 4 * TD;
  localparam int HALF      = 2 * TD;
  localparam int LAT_MIN   = 2 + 38 * TD;
  localparam int LAT_MAX   = 4 + 38 * TD;
  localparam int HIST      = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx;
  logic [7:0] rx_data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         dv_cyc[$];
  logic [7:0] dv_dat[$];
  int         fe_cyc[$];
  int         both_cnt = 0;
  logic       busy_hist [0:HIST-1];
  logic [7:0] last_good;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rx(rx),
    .rx_data(rx_data), .data_valid(data_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output event away from the active edge.
  always @(negedge clk) begin
    if (cyc < HIST) busy_hist[cyc] = busy;
    if (data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_dat.push_back(rx_data);
    end
    if (frame_error === 1'b1) fe_cyc.push_back(cyc);
    if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt++;
  end

  // Line level t clocks after the start edge for a frame with bit time bt.
  function automatic logic line_at(input logic [7:0] b, input int bt, input logic stop, input int t);
    int slot;
    slot = t / bt;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return b[slot-1];
    else if (slot == 9) return stop;
    else return 1'b1;
  endfunction

  // Receiver view of a frame: {stop sample, byte} taken at half a nominal bit plus whole bits.
  function automatic logic [8:0] model_frame(input logic [7:0] b, input int bt, input logic stop);
    logic [8:0] r;
    for (int k = 0; k < 8; k++) r[k] = line_at(b, bt, stop, HALF + BIT * (k + 1));
    r[8] = line_at(b, bt, stop, HALF + BIT * 9);
    return r;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bits(input logic lvl, input int n);
    rx = lvl;
    wait_cycles(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop, output int s);
    s = cyc;
    drive_bits(1'b0, bt);
    for (int k = 0; k < 8; k++) drive_bits(b[k], bt);
    drive_bits(stop, bt);
    rx = 1'b1;
  endtask

  task automatic clear_events();
    dv_cyc.delete();
    dv_dat.delete();
    fe_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %b want 0", data_valid); else n_pass++;
    n_checks++; if (frame_error !== 1'b0) $display("FAIL reset_frame_error got %b want 0", frame_error); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    last_good = 8'h00;
    wait_cycles(5);
  endtask

  task automatic test_nominal();
    int s, lat, lows;
    logic [8:0] m;
    clear_events();
    m = model_frame(8'hA5, BIT, 1'b1);
    send_frame(8'hA5, BIT, 1'b1, s);
    wait_cycles(20);
    lat = (dv_cyc.size() > 0) ? dv_cyc[0] - s : -1;
    lows = 0;
    for (int c = s + 4; c <= s + 381; c++) if (busy_hist[c] !== 1'b1) lows++;
    n_checks++; if (dv_cyc.size() != 1) $display("FAIL nominal_dv_count got %0d want 1", dv_cyc.size()); else n_pass++;
    n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL nominal_latency got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); else n_pass++;
    n_checks++; if (rx_data !== m[7:0]) $display("FAIL nominal_rx_data got %h want %h", rx_data, m[7:0]); else n_pass++;
    n_checks++; if (fe_cyc.size() != 0) $display("FAIL nominal_fe_count got %0d want 0", fe_cyc.size()); else n_pass++;
    n_checks++; if (lows != 0) $display("FAIL nominal_busy_low_cycles got %0d want 0", lows); else n_pass++;
    n_checks++; if (busy_hist[s + LAT_MAX + 2] !== 1'b0) $display("FAIL nominal_busy_after got %b want 0", busy_hist[s + LAT_MAX + 2]); else n_pass++;
    last_good = m[7:0];
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    logic [7:0] got;
    logic [8:0] m;
    int starts[$];
    int s, lat;
    clear_events();
    for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom_range(0, 255)));
    bytes.push_back(8'h00);
    bytes.push_back(8'hFF);
    foreach (bytes[i]) begin
      send_frame(bytes[i], BIT, 1'b1, s);
      starts.push_back(s);
    end
    wait_cycles(30);
    n_checks++; if (dv_cyc.size() != bytes.size()) $display("FAIL b2b_dv_count got %0d want %0d", dv_cyc.size(), bytes.size()); else n_pass++;
    n_checks++; if (fe_cyc.size() != 0 || both_cnt != 0) $display("FAIL b2b_fe_count got %0d/%0d want 0/0", fe_cyc.size(), both_cnt); else n_pass++;
    foreach (bytes[i]) begin
      m = model_frame(bytes[i], BIT, 1'b1);
      got = (i < dv_cyc.size()) ? dv_dat[i] : 8'hxx;
      lat = (i < dv_cyc.size()) ? dv_cyc[i] - starts[i] : -1;
      n_checks++; if (got !== m[7:0]) $display("FAIL b2b_data[%0d] got %h want %h", i, got, m[7:0]); else n_pass++;
      n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL b2b_latency[%0d] got %0d want %0d..%0d", i, lat, LAT_MIN, LAT_MAX); else n_pass++;
      last_good = m[7:0];
    end
  endtask

  task automatic test_frame_error();
    int s, lat, want_fe;
    logic [8:0] m;
    clear_events();
    m = model_frame(8'h3C, BIT, 1'b0);
    want_fe = (m[8] == 1'b0) ? 1 : 0;
    send_frame(8'h3C, BIT, 1'b0, s);
    wait_cycles(80);
    lat = (fe_cyc.size() > 0) ? fe_cyc[0] - s : -1;
    n_checks++; if (fe_cyc.size() != want_fe) $display("FAIL ferr_fe_count got %0d want %0d", fe_cyc.size(), want_fe); else n_pass++;
    n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL ferr_latency got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); else n_pass++;
    n_checks++; if (dv_cyc.size() != 0) $display("FAIL ferr_dv_count got %0d want 0", dv_cyc.size()); else n_pass++;
    n_checks++; if (rx_data !== last_good) $display("FAIL ferr_rx_data got %h want %h", rx_data, last_good); else n_pass++;
  endtask

  task automatic test_false_start();
    int s;
    logic [8:0] m;
    clear_events();
    s = cyc;
    drive_bits(1'b0, 12);
    drive_bits(1'b1, 60);
    n_checks++; if (busy_hist[s + 5] !== 1'b1) $display("FAIL fstart_busy_rise got %b want 1", busy_hist[s + 5]); else n_pass++;
    n_checks++; if (busy_hist[s + 24] !== 1'b0) $display("FAIL fstart_busy_fall got %b want 0", busy_hist[s + 24]); else n_pass++;
    n_checks++; if (dv_cyc.size() != 0 || fe_cyc.size() != 0) $display("FAIL fstart_pulses got %0d/%0d want 0/0", dv_cyc.size(), fe_cyc.size()); else n_pass++;
    m = model_frame(8'h81, BIT, 1'b1);
    send_frame(8'h81, BIT, 1'b1, s);
    wait_cycles(20);
    n_checks++; if (dv_cyc.size() != 1) $display("FAIL fstart_next_dv_count got %0d want 1", dv_cyc.size()); else n_pass++;
    n_checks++; if (rx_data !== m[7:0]) $display("FAIL fstart_next_rx_data got %h want %h", rx_data, m[7:0]); else n_pass++;
    last_good = m[7:0];
  endtask

  task automatic test_enable_mid();
    int s, e;
    logic [7:0] b;
    logic [8:0] m;
    b = 8'h55;
    clear_events();
    drive_bits(1'b0, BIT);
    for (int k = 0; k < 4; k++) drive_bits(b[k], BIT);
    enable = 1'b0;
    rx = 1'b1;
    e = cyc;
    wait_cycles(10);
    n_checks++; if (busy_hist[e - 1] !== 1'b1) $display("FAIL en_busy_before got %b want 1", busy_hist[e - 1]); else n_pass++;
    n_checks++; if (busy_hist[e + 1] !== 1'b0) $display("FAIL en_busy_after got %b want 0", busy_hist[e + 1]); else n_pass++;
    n_checks++; if (dv_cyc.size() != 0 || fe_cyc.size() != 0) $display("FAIL en_pulses got %0d/%0d want 0/0", dv_cyc.size(), fe_cyc.size()); else n_pass++;
    n_checks++; if (rx_data !== last_good) $display("FAIL en_rx_data_kept got %h want %h", rx_data, last_good); else n_pass++;
    enable = 1'b1;
    wait_cycles(20);
    m = model_frame(b, BIT, 1'b1);
    send_frame(b, BIT, 1'b1, s);
    wait_cycles(20);
    n_checks++; if (dv_cyc.size() != 1) $display("FAIL en_resume_dv_count got %0d want 1", dv_cyc.size()); else n_pass++;
    n_checks++; if (rx_data !== m[7:0]) $display("FAIL en_resume_rx_data got %h want %h", rx_data, m[7:0]); else n_pass++;
    last_good = m[7:0];
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] b;
    logic [8:0] m;
    b = 8'h55;
    clear_events();
    drive_bits(1'b0, BIT);
    for (int k = 0; k < 4; k++) drive_bits(b[k], BIT);
    rst = 1'b1;
    rx = 1'b1;
    #1;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (data_valid !== 1'b0 || frame_error !== 1'b0) $display("FAIL rstmid_pulses got %b/%b want 0/0", data_valid, frame_error); else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_good = 8'h00;
    wait_cycles(20);
    n_checks++; if (dv_cyc.size() != 0 || fe_cyc.size() != 0) $display("FAIL rstmid_no_pulse got %0d/%0d want 0/0", dv_cyc.size(), fe_cyc.size()); else n_pass++;
    m = model_frame(b, BIT, 1'b1);
    send_frame(b, BIT, 1'b1, s);
    wait_cycles(20);
    n_checks++; if (dv_cyc.size() != 1) $display("FAIL rstmid_resume_dv_count got %0d want 1", dv_cyc.size()); else n_pass++;
    n_checks++; if (rx_data !== m[7:0]) $display("FAIL rstmid_resume_rx_data got %h want %h", rx_data, m[7:0]); else n_pass++;
    last_good = m[7:0];
  endtask

  task automatic test_tolerance();
    int bts[$];
    logic [7:0] bytes[$];
    logic [8:0] m;
    int s;
    bts.push_back(38); bytes.push_back(8'h6E);
    bts.push_back(42); bytes.push_back(8'h6E);
    for (int i = 0; i < 4; i++) begin
      bts.push_back(int'($urandom_range(38, 42)));
      bytes.push_back(8'($urandom_range(0, 255)));
    end
    foreach (bytes[i]) begin
      clear_events();
      m = model_frame(bytes[i], bts[i], 1'b1);
      send_frame(bytes[i], bts[i], 1'b1, s);
      wait_cycles(30);
      n_checks++; if (dv_cyc.size() != 1) $display("FAIL tol_dv_count[%0d] bt=%0d got %0d want 1", i, bts[i], dv_cyc.size()); else n_pass++;
      n_checks++; if (rx_data !== m[7:0]) $display("FAIL tol_rx_data[%0d] bt=%0d got %h want %h", i, bts[i], rx_data, m[7:0]); else n_pass++;
      n_checks++; if (fe_cyc.size() != 0) $display("FAIL tol_fe_count[%0d] bt=%0d got %0d want 0", i, bts[i], fe_cyc.size()); else n_pass++;
      last_good = m[7:0];
    end
    n_checks++; if (both_cnt != 0) $display("FAIL both_pulses got %0d want 0", both_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_enable_mid();
    test_reset_mid();
    test_tolerance();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
